tmr_fault_injector: RTL

- Campaign-driven fault injector placed between the three replica result buses of the TMR core and the majority voter.
- Corrupts one replica's result with a single-bit flip for exactly one cycle, on a deterministic, periodic or pseudo-random schedule.
- Watches the voter's per-replica fault flags to count each injected fault as detected or missed.
- It is the stimulus end of the fault-flag interface; the voter and the bench fault counters are the observing end.

---
 rtl/tmr_fault_injector.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/tmr_fault_injector.sv
// Purpose : campaign-driven single-bit fault injector between the TMR replica result buses and the
//           majority voter. It scores each injected fault as detected or missed from the voter fault flags.
// Latency : result path is purely combinational (zero cycles). The k-th injection lands at cycle
//           (k-1)*(interval+1+DETECT_WIN)+interval after the start edge.
// Backpressure: none. start_i is ignored while busy, and abort_i returns the FSM to IDLE on the next edge.
// Ports   : clk/reset_n; start_i, abort_i, mode_i, target_i, bit_i, interval_i, count_i (campaign control);
//           result_{A,B,C}_i -> result_{A,B,C}_o (corrupted pass-through); fault_{A,B,C}_i (voter flags);
//           inject_o, busy_o, done_o, injected_o, detected_o, missed_o (status and statistics).
module tmr_fault_injector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned DETECT_WIN = 2,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [1:0]            mode_i,
  input  logic [1:0]            target_i,
  input  logic [4:0]            bit_i,
  input  logic [CNT_WIDTH-1:0]  interval_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  input  logic [DATA_WIDTH-1:0] result_A_i,
  input  logic [DATA_WIDTH-1:0] result_B_i,
  input  logic [DATA_WIDTH-1:0] result_C_i,
  output logic [DATA_WIDTH-1:0] result_A_o,
  output logic [DATA_WIDTH-1:0] result_B_o,
  output logic [DATA_WIDTH-1:0] result_C_o,
  input  logic                  fault_A_i,
  input  logic                  fault_B_i,
  input  logic                  fault_C_i,
  output logic [2:0]            inject_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  injected_o,
  output logic [CNT_WIDTH-1:0]  detected_o,
  output logic [CNT_WIDTH-1:0]  missed_o
);

  localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;
  localparam int unsigned          WIN_W     = (DETECT_WIN < 2) ? 1 : $clog2(DETECT_WIN + 1);
  localparam logic [WIN_W-1:0]     WIN_LOAD  = WIN_W'(DETECT_WIN);
  localparam logic [WIN_W-1:0]     WIN_ONE   = WIN_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   WAIT_ONE  = (CNT_WIDTH + 1)'(1);
  localparam logic [1:0]           MODE_SINGLE = 2'b00;
  localparam logic [1:0]           MODE_RANDOM = 2'b10;
  localparam logic [1:0]           TGT_ROTATE  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_INJECT, S_CHECK, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_mode;
  logic [1:0]            r_tgt_cfg;
  logic [4:0]            r_bit;
  logic [CNT_WIDTH-1:0]  r_interval;
  logic [1:0]            r_tgt;        // replica index 0..2 hit by the next injection
  logic [2:0]            r_chk_oh;     // replica whose flag is being watched in CHECK
  logic [CNT_WIDTH:0]    r_wait_cnt;   // one bit wider: random wait can reach 2^CNT_WIDTH
  logic [WIN_W-1:0]      r_win;
  logic [CNT_WIDTH-1:0]  r_remain;
  logic                  r_det;
  logic [CNT_WIDTH-1:0]  r_injected;
  logic [CNT_WIDTH-1:0]  r_detected;
  logic [CNT_WIDTH-1:0]  r_missed;
  logic [31:0]           r_lfsr;

  logic [2:0]            w_inject;
  logic [2:0]            w_flags;
  logic                  w_hit_inj;
  logic                  w_hit_chk;
  logic [4:0]            w_bit_sel;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [CNT_WIDTH-1:0]  w_eff_cnt;
  logic [1:0]            w_tgt_init;

  // Wait length for the next WAIT. Interval 0 behaves as 1. Random mode masks the LFSR with the interval.
  function automatic logic [CNT_WIDTH:0] f_wait_len(input logic [1:0]           mode,
                                                    input logic [CNT_WIDTH-1:0] ivl,
                                                    input logic [31:0]          lfsr);
    logic [CNT_WIDTH:0] len;
    if (mode == MODE_RANDOM) begin
      len = {1'b0, lfsr[CNT_WIDTH-1:0] & ivl} + WAIT_ONE;
    end else if (ivl == '0) begin
      len = WAIT_ONE;
    end else begin
      len = {1'b0, ivl};
    end
    return len;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign w_eff_cnt  = (mode_i == MODE_SINGLE) ? CNT_ONE : count_i;
  assign w_tgt_init = (target_i == TGT_ROTATE) ? 2'd0 : target_i;
  assign w_flags    = {fault_C_i, fault_B_i, fault_A_i};
  assign w_hit_inj  = |(w_inject & w_flags);
  assign w_hit_chk  = |(r_chk_oh & w_flags);
  assign w_bit_sel  = (r_mode == MODE_RANDOM) ? r_lfsr[4:0] : r_bit;
  assign w_mask     = DATA_WIDTH'(1) << w_bit_sel;

  // Zero-latency datapath: only the replica marked in inject_o is corrupted.
  assign result_A_o = w_inject[0] ? (result_A_i ^ w_mask) : result_A_i;
  assign result_B_o = w_inject[1] ? (result_B_i ^ w_mask) : result_B_i;
  assign result_C_o = w_inject[2] ? (result_C_i ^ w_mask) : result_C_i;
  assign inject_o   = w_inject;

  assign injected_o = r_injected;
  assign detected_o = r_detected;
  assign missed_o   = r_missed;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. abort_i overrides everything, including a start in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_next = (w_eff_cnt == '0) ? S_DONE : S_WAIT;
      S_WAIT:   if (r_wait_cnt == WAIT_ONE) w_next = S_INJECT;
      S_INJECT: w_next = S_CHECK;
      S_CHECK:  if (r_win == WIN_ONE) w_next = (r_remain > CNT_ONE) ? S_WAIT : S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end

  // Output decode
  always_comb begin
    w_inject = 3'b000;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (r_state)
      S_WAIT:   busy_o = 1'b1;
      S_INJECT: begin
        busy_o = 1'b1;
        case (r_tgt)
          2'd0:    w_inject = 3'b001;
          2'd1:    w_inject = 3'b010;
          default: w_inject = 3'b100;
        endcase
      end
      S_CHECK:  busy_o = 1'b1;
      S_DONE:   done_o = 1'b1;
      default:  ;
    endcase
  end

  // Campaign datapath: config, counters, detection window, LFSR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= 2'b00;
      r_tgt_cfg  <= 2'b00;
      r_bit      <= 5'd0;
      r_interval <= '0;
      r_tgt      <= 2'd0;
      r_chk_oh   <= 3'b000;
      r_wait_cnt <= '0;
      r_win      <= '0;
      r_remain   <= '0;
      r_det      <= 1'b0;
      r_injected <= '0;
      r_detected <= '0;
      r_missed   <= '0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      if (r_state != S_IDLE) begin
        r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
      end
      case (r_state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            r_mode     <= mode_i;
            r_tgt_cfg  <= target_i;
            r_bit      <= bit_i;
            r_interval <= interval_i;
            r_tgt      <= w_tgt_init;
            r_remain   <= w_eff_cnt;
            r_wait_cnt <= f_wait_len(mode_i, interval_i, r_lfsr);
            r_injected <= '0;
            r_detected <= '0;
            r_missed   <= '0;
          end
        end
        S_WAIT: r_wait_cnt <= r_wait_cnt - WAIT_ONE;
        S_INJECT: begin
          // The injection is already on the bus this cycle, so it is counted even if aborted.
          r_injected <= f_sat_inc(r_injected);
          r_chk_oh   <= w_inject;
          r_det      <= w_hit_inj;
          r_win      <= WIN_LOAD;
          if (r_tgt_cfg == TGT_ROTATE) begin
            r_tgt <= (r_tgt == 2'd2) ? 2'd0 : r_tgt + 2'd1;
          end
        end
        S_CHECK: begin
          if (!abort_i) begin
            r_win <= r_win - WIN_ONE;
            r_det <= r_det | w_hit_chk;
            if (r_win == WIN_ONE) begin
              if (r_det || w_hit_chk) r_detected <= f_sat_inc(r_detected);
              else                    r_missed   <= f_sat_inc(r_missed);
              r_remain   <= r_remain - CNT_ONE;
              r_wait_cnt <= f_wait_len(r_mode, r_interval, r_lfsr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
